// File: rtl/t06_wall_pkg.sv
// rtl/t06_wall_pkg.sv - shared constants and types for the snake wall generator
package t06_wall_pkg;

    localparam int NUM_WALLS = 25;
    localparam int GRID_ROWS = 12;

    localparam logic [7:0] WALL_SENTINEL = 8'hFF;
    localparam logic [7:0] LFSR_SEED     = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } wall_state_e;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } pos_t;

endpackage

// File: rtl/t06_lfsr8.sv
// rtl/t06_lfsr8.sv - free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1
module t06_lfsr8
    import t06_wall_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Shift left, feeding back the XOR of the tap bits; maximal length so 0 never appears
    always_comb begin
        q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
    end

    // Register with seed on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/t06_wall_gen.sv
// rtl/t06_wall_gen.sv - randomised wall layout generator; option T06_WALL_SAFE_ZONE_EN
module t06_wall_gen #(
    parameter int NUM_WALLS = t06_wall_pkg::NUM_WALLS,
    parameter int GRID_ROWS = t06_wall_pkg::GRID_ROWS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4:0]             wall_count,
    input  logic [7:0]             head_pos,
    input  logic [7:0]             apple_pos,
    output logic [8*NUM_WALLS-1:0] walls,
    output logic                   busy,
    output logic                   done
);
    import t06_wall_pkg::*;

    localparam logic [3:0] ROWS4  = 4'(GRID_ROWS);
    localparam logic [4:0] MAX_N  = 5'(NUM_WALLS);

    wall_state_e           state_q, state_d;
    logic [4:0]            count_q, count_d;
    logic [4:0]            idx_q, idx_d;
    pos_t                  head_q, head_d;
    logic [7:0]            apple_q, apple_d;
    logic [8*NUM_WALLS-1:0] walls_q, walls_d;

    logic [7:0] lfsr_q;
    pos_t       cand;
    logic       dup_hit;
    logic       near_head;
    logic       reject;

    t06_lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Candidate screening: off-board rows, head/apple cells and already placed walls
    always_comb begin
        cand    = pos_t'(lfsr_q);
        dup_hit = 1'b0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            if (walls_q[8*i +: 8] == cand) begin
                dup_hit = 1'b1;
            end
        end
`ifdef T06_WALL_SAFE_ZONE_EN
        begin
            logic [4:0] dx;
            logic [4:0] dy;
            dx = {1'b0, cand.x} - {1'b0, head_q.x};
            dy = {1'b0, cand.y} - {1'b0, head_q.y};
            near_head = ((dx == 5'd0) || (dx == 5'd1) || (dx == 5'h1F)) &&
                        ((dy == 5'd0) || (dy == 5'd1) || (dy == 5'h1F));
        end
`else
        near_head = (cand == head_q);
`endif
        reject = (cand.y >= ROWS4) || near_head || (cand == apple_q) || dup_hit;
    end

    // Layout state machine: latch request, place accepted cells slot by slot, pulse done
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        head_d  = head_q;
        apple_d = apple_q;
        walls_d = walls_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = GEN;
                    count_d = (wall_count > MAX_N) ? MAX_N : wall_count;
                    head_d  = pos_t'(head_pos);
                    apple_d = apple_pos;
                    walls_d = {NUM_WALLS{WALL_SENTINEL}};
                    idx_d   = 5'd0;
                end
            end
            GEN: begin
                if ((idx_q != count_q) && !reject) begin
                    for (int i = 0; i < NUM_WALLS; i++) begin
                        if (idx_q == 5'(i)) begin
                            walls_d[8*i +: 8] = cand;
                        end
                    end
                    idx_d = idx_q + 5'd1;
                end
                // Leave as soon as the final acceptance lands so DONE follows it directly
                if (idx_d == count_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= 5'd0;
            idx_q   <= 5'd0;
            head_q  <= pos_t'(8'h00);
            apple_q <= 8'h00;
            walls_q <= {NUM_WALLS{WALL_SENTINEL}};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            head_q  <= head_d;
            apple_q <= apple_d;
            walls_q <= walls_d;
        end
    end

    assign walls = walls_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: doc/t06_wall_gen.md
# t06_wall_gen

Generates the randomised wall layout for the snake game and drives the packed 25-slot wall bus read by the wall collision checker. On a `start` pulse it draws candidate cells from a free-running 8-bit LFSR. It rejects illegal or duplicate cells and writes accepted cells into consecutive slots until the requested count is placed. Unused slots hold an off-board sentinel so they never match the snake's next position.

## Interface
Parameters:
- `NUM_WALLS`, 25: number of wall slots on the output bus.
- `GRID_ROWS`, 12: number of valid y rows. x spans 0..15; y spans 0..GRID_ROWS-1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse requesting a new layout. Sampled only in IDLE.
- `wall_count`  in  5  number of walls to place. Sampled with `start`; values above 25 clamp to 25.
- `head_pos`  in  8  snake head position, [7:4]=x, [3:0]=y. Sampled with `start`.
- `apple_pos`  in  8  apple position, same format. Sampled with `start`.
- `walls`  out  200  slot i occupies bits [8i+7:8i], same position format.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when the layout is complete.

## Operation
- State machine:
  - IDLE, on `start`: go to GEN. Latch the clamped count, `head_pos` and `apple_pos`. Set every slot to the sentinel 8'hFF and clear the slot index to 0.
  - GEN, when index == latched count: go to DONE.
  - DONE: go to IDLE.
- LFSR:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1. Reset value 8'h01.
  - Advances every cycle in all states, so placement depends on when `start` arrives.
  - Never produces 8'h00, so cell (0,0) is never a wall.
- GEN cycle: the current LFSR value is the candidate. It is rejected if any of the following holds:
  - y >= GRID_ROWS;
  - it equals the latched head or apple position;
  - it equals any already-written slot (compare against all 25 slots; the sentinel can never match because y=15 is already rejected).
- An accepted candidate is written to slot[index] at the clock edge and the index increments by 1. A rejected candidate changes nothing.
- Guaranteed completion: the LFSR visits every nonzero value once per 255-cycle period. At most 27 cells are ever excluded (25 placed, plus head and apple) out of 191 reachable cells. So at most 25 acceptances are needed, and GEN always ends within 255 cycles.
- `start` while `busy` is ignored. `wall_count`, `head_pos` and `apple_pos` changes after the latch have no effect on the layout in progress.
- Reset at any time:
  - state IDLE, index 0;
  - all slots 8'hFF;
  - LFSR 8'h01;
  - `busy`=0, `done`=0.
- Slots update progressively during GEN. Consumers treat `walls` as valid only when `busy`=0.

## Timing
- Reset values: `walls`=200 bits all 1, `busy`=0, `done`=0.
- `start` high in cycle T: GEN from T+1. `busy` is high from T+1. The slots are cleared to the sentinel at the T/T+1 edge.
- Each GEN cycle evaluates one candidate. An acceptance is visible on `walls` the following cycle.
- With N acceptances, the last occurring in GEN cycle G: DONE in G+1 with `done`=1, then IDLE in G+2 with `busy`=0.
- `wall_count`=0: GEN in T+1, DONE in T+2, IDLE in T+3. All slots stay 8'hFF.
- Worst case from `start` to `done`: 257 cycles.

## Configuration
- `T06_WALL_SAFE_ZONE_EN`:
  - Defined: a candidate is also rejected if it lies within Chebyshev distance 1 of the latched head (the 3x3 block around the head, clipped at board edges). This guarantees the snake a free first move.
  - Undefined: the head exclusion is exact equality only.
- The completion bound still holds with the macro defined: at most 35 cells are excluded.

## Structure
- Package `t06_wall_pkg` holds:
  - `NUM_WALLS`, `GRID_ROWS`;
  - `WALL_SENTINEL` = 8'hFF;
  - the LFSR seed;
  - the state enum {IDLE, GEN, DONE};
  - the packed position typedef (x nibble, y nibble).
- Sub-module `t06_lfsr8`:
  - inputs `clk`, `rst`; output `q`[7:0];
  - free-running, reusable for apple placement.

## Test plan
- Reset check: assert `rst` for 2 cycles. Expect `walls` all 1s, `busy`=0 and `done`=0 throughout.
- Zero walls: `start` with `wall_count`=0. Expect `done` exactly at T+2, `busy` low at T+3, all slots 8'hFF.
- Full layout: `start` with `wall_count`=25, `head_pos`=8'h55, `apple_pos`=8'hA3. Expect `done` within 257 cycles and slots 0..24 all distinct. Each slot has y<12 and differs from 8'h55 and 8'hA3.
- Overflow clamp: `wall_count`=31 behaves identically to 25. Exactly 25 non-sentinel slots.
- Busy protection: pulse `start` again mid-GEN with a different `head_pos`. Expect no restart and no new latch. A single `done`.
- Reset mid-GEN: assert `rst` after 10 GEN cycles. Expect IDLE with all slots 8'hFF next cycle. With `T06_WALL_SAFE_ZONE_EN` defined and `head_pos`=8'h00, no slot equals 8'h01, 8'h10 or 8'h11.
